// File: rtl/rs232_pkg.sv
// ---------------------------------------------------------------------------
// rs232_pkg
// Shared definitions for the rs232_phy 8N1 serial transceiver:
//   - bit_cycles(): clock cycles per bit period (integer division)
//   - rx_state_e / tx_state_e: receiver and transmitter FSM states
//   - DATA_BITS: data bits per frame
// ---------------------------------------------------------------------------
package rs232_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic int bit_cycles(input int frequency, input int bps);
        return frequency / bps;
    endfunction

endpackage

// File: rtl/rs232_bit_timer.sv
// ---------------------------------------------------------------------------
// rs232_bit_timer
// Loadable down-counter that marks the end of an interval. Loading value L
// on an edge makes o_expire high during the L-th cycle after that edge, so
// the owner acting on o_expire sees intervals of exactly L cycles. A reload
// on the expiry cycle chains intervals without a gap. The counter rests at
// zero when not reloaded, and o_expire stays low there.
// Ports:
//   clock     in   1      system clock
//   reset_n   in   1      asynchronous active-low reset
//   i_load    in   1      load i_value into the counter
//   i_value   in   CNT_W  interval length in cycles (>= 1)
//   o_expire  out  1      last cycle of the current interval
// ---------------------------------------------------------------------------
module rs232_bit_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_expire = (r_count == CNT_W'(1));

endmodule

// File: rtl/rs232_phy.sv
// ---------------------------------------------------------------------------
// rs232_phy
// Byte-level 8N1 asynchronous serial transceiver (LSB first, no parity,
// one stop bit, idle-high line). Receiver and transmitter are independent
// and share only the clock and reset.
// Optional feature macro: RS232_FRAMING_ERR_EN adds the framing_error port.
// Ports:
//   clock          in   1  system clock, rising edge
//   reset_n        in   1  asynchronous active-low reset
//   serial_in      in   1  RX line, asynchronous to clock
//   serial_out     out  1  TX line
//   d              in   8  byte to transmit, latched on acceptance
//   we             in   1  transmit request (accepted when not busy)
//   busy           out  1  transmitter occupied
//   valid          out  1  one-cycle pulse: new byte on q
//   q              out  8  last received byte
//   framing_error  out  1  (RS232_FRAMING_ERR_EN only) pulse on bad stop bit
// ---------------------------------------------------------------------------
module rs232_phy
    import rs232_pkg::*;
#(
    parameter int frequency = 50_000_000,
    parameter int bps       = 115_200
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       serial_in,
    output logic       serial_out,
    input  logic [7:0] d,
    input  logic       we,
    output logic       busy,
    output logic       valid,
    output logic [7:0] q
`ifdef RS232_FRAMING_ERR_EN
    ,
    output logic       framing_error
`endif
);

    localparam int               BIT      = bit_cycles(frequency, bps);
    localparam int               CNT_W    = $clog2(BIT) + 1;
    localparam logic [CNT_W-1:0] LP_BIT   = CNT_W'(BIT);
    localparam logic [CNT_W-1:0] LP_HALF  = CNT_W'(BIT / 2);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    // =======================================================================
    // Transmitter
    // =======================================================================
    tx_state_e  r_tx_state;
    tx_state_e  w_tx_next;
    logic       w_tx_load;
    logic       w_tx_accept;
    logic       w_tx_expire;
    logic [2:0] r_tx_bitcnt;
    logic [7:0] r_tx_shift;
    logic       r_tx_out;
    logic       r_busy;

    rs232_bit_timer #(
        .CNT_W (CNT_W)
    ) u_tx_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_load   (w_tx_load),
        .i_value  (LP_BIT),
        .o_expire (w_tx_expire)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    always_comb begin
        w_tx_next   = r_tx_state;
        w_tx_load   = 1'b0;
        w_tx_accept = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (we) begin
                    w_tx_accept = 1'b1;
                end
            end
            TX_START: begin
                if (w_tx_expire) begin
                    w_tx_next = TX_DATA;
                    w_tx_load = 1'b1;
                end
            end
            TX_DATA: begin
                if (w_tx_expire) begin
                    w_tx_load = 1'b1;
                    if (r_tx_bitcnt == LAST_BIT) begin
                        w_tx_next = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                // A request on the final stop cycle chains the next frame
                // straight after this one, with no idle gap.
                if (w_tx_expire) begin
                    if (we) begin
                        w_tx_accept = 1'b1;
                    end else begin
                        w_tx_next = TX_IDLE;
                    end
                end
            end
            default: begin
                w_tx_next = TX_IDLE;
            end
        endcase
        if (w_tx_accept) begin
            w_tx_next = TX_START;
            w_tx_load = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_out    <= 1'b1;
            r_busy      <= 1'b0;
            r_tx_bitcnt <= 3'd0;
        end else if (w_tx_accept) begin
            r_tx_out    <= 1'b0;
            r_busy      <= 1'b1;
            r_tx_bitcnt <= 3'd0;
        end else if (w_tx_expire) begin
            case (r_tx_state)
                TX_START: r_tx_out <= r_tx_shift[0];
                TX_DATA: begin
                    // Ones shifted in at the top make bit 1 the stop level
                    // once the last data bit has been sent.
                    r_tx_out    <= r_tx_shift[1];
                    r_tx_bitcnt <= r_tx_bitcnt + 3'd1;
                end
                TX_STOP: r_busy <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_tx_accept) begin
            r_tx_shift <= d;
        end else if ((r_tx_state == TX_DATA) && w_tx_expire) begin
            r_tx_shift <= {1'b1, r_tx_shift[7:1]};
        end
    end

    assign serial_out = r_tx_out;
    assign busy       = r_busy;

    // =======================================================================
    // Receiver
    // =======================================================================
    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    rx_state_e        r_rx_state;
    rx_state_e        w_rx_next;
    logic             w_rx_load;
    logic [CNT_W-1:0] w_rx_load_val;
    logic             w_rx_expire;
    logic [2:0]       r_rx_bitcnt;
    logic [7:0]       r_rx_shift;
    logic             r_rx_brk;
    logic             r_valid;
    logic [7:0]       r_q;
    logic             w_rx_fall;
    logic             w_stop_sample;
    logic             w_stop_ok;
    logic             w_stop_bad;

    // Two-flop synchronizer plus one history flop for edge detection; all
    // reset to the idle-high level so reset release cannot fake a start bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= serial_in;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx_fall     = r_rx_prev & ~r_sync2;
    assign w_stop_sample = (r_rx_state == RX_STOP) && !r_rx_brk && w_rx_expire;
    assign w_stop_ok     = w_stop_sample && r_sync2;
    assign w_stop_bad    = w_stop_sample && !r_sync2;

    rs232_bit_timer #(
        .CNT_W (CNT_W)
    ) u_rx_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_load   (w_rx_load),
        .i_value  (w_rx_load_val),
        .o_expire (w_rx_expire)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next     = r_rx_state;
        w_rx_load     = 1'b0;
        w_rx_load_val = LP_BIT;
        case (r_rx_state)
            RX_IDLE: begin
                // Half a bit first, so all later samples land mid-bit.
                if (w_rx_fall) begin
                    w_rx_next     = RX_START;
                    w_rx_load     = 1'b1;
                    w_rx_load_val = LP_HALF;
                end
            end
            RX_START: begin
                if (w_rx_expire) begin
                    if (r_sync2) begin
                        w_rx_next = RX_IDLE;
                    end else begin
                        w_rx_next = RX_DATA;
                        w_rx_load = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (w_rx_expire) begin
                    w_rx_load = 1'b1;
                    if (r_rx_bitcnt == LAST_BIT) begin
                        w_rx_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                // After a low stop bit, hold here until the line is high
                // again so a break cannot be mistaken for new start bits.
                if (w_stop_ok || (r_rx_brk && r_sync2)) begin
                    w_rx_next = RX_IDLE;
                end
            end
            default: begin
                w_rx_next = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_bitcnt <= 3'd0;
            r_rx_brk    <= 1'b0;
            r_valid     <= 1'b0;
            r_q         <= 8'h00;
        end else begin
            r_valid <= w_stop_ok;
            if (w_stop_ok) begin
                r_q <= r_rx_shift;
            end
            if (w_stop_bad) begin
                r_rx_brk <= 1'b1;
            end else if (r_rx_state == RX_IDLE) begin
                r_rx_brk <= 1'b0;
            end
            if (r_rx_state == RX_IDLE) begin
                r_rx_bitcnt <= 3'd0;
            end else if ((r_rx_state == RX_DATA) && w_rx_expire) begin
                r_rx_bitcnt <= r_rx_bitcnt + 3'd1;
            end
        end
    end

    // LSB arrives first and ends up in bit 0 after eight right shifts.
    always_ff @(posedge clock) begin
        if ((r_rx_state == RX_DATA) && w_rx_expire) begin
            r_rx_shift <= {r_sync2, r_rx_shift[7:1]};
        end
    end

    assign valid = r_valid;
    assign q     = r_q;

`ifdef RS232_FRAMING_ERR_EN
    logic r_ferr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ferr <= 1'b0;
        end else begin
            r_ferr <= w_stop_bad;
        end
    end

    assign framing_error = r_ferr;
`endif

endmodule

// File: tb/tb_rs232_phy.sv
// ---------------------------------------------------------------------------
// tb_rs232_phy
// Self-checking bench for rs232_phy at frequency=1_000_000, bps=100_000
// (10 cycles per bit). Expected line waveforms and received bytes come from
// a frame-level model: a frame is the 10-bit list {start=0, d[0..7], stop=1},
// each bit held for one bit period.
// ---------------------------------------------------------------------------
module tb_rs232_phy;

    localparam int BITC = 10;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       serial_in;
    logic       serial_out;
    logic [7:0] d;
    logic       we;
    logic       busy;
    logic       valid;
    logic [7:0] q;
`ifdef RS232_FRAMING_ERR_EN
    logic       framing_error;
`endif

    logic       tb_rx;
    logic       loop_en;

    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    int         n_ferr  = 0;
    logic [7:0] got_q[$];
    int         got_t[$];

    assign serial_in = loop_en ? serial_out : tb_rx;

    rs232_phy #(
        .frequency (1_000_000),
        .bps       (100_000)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .serial_in     (serial_in),
        .serial_out    (serial_out),
        .d             (d),
        .we            (we),
        .busy          (busy),
        .valid         (valid),
        .q             (q)
`ifdef RS232_FRAMING_ERR_EN
        ,
        .framing_error (framing_error)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Receive monitor: one entry per cycle that valid is high.
    always @(negedge clock) begin
        if (valid === 1'b1) begin
            got_q.push_back(q);
            got_t.push_back(cyc);
        end
`ifdef RS232_FRAMING_ERR_EN
        if (framing_error === 1'b1) n_ferr++;
`endif
    end

    function automatic logic [9:0] frame_bits(input logic [7:0] b, input logic stop_bit);
        return {stop_bit, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fb;
        fb = frame_bits(b, stop_bit);
        for (int i = 0; i < 10; i++) begin
            tb_rx = fb[i];
            repeat (BITC) @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        we      = 1'b0;
        d       = 8'h00;
        tb_rx   = 1'b1;
        loop_en = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_total++;
        if (serial_out !== 1'b1) $display("FAIL reset_serial_out: got %b want 1", serial_out);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else n_pass++;
        n_total++;
        if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid);
        else n_pass++;
        n_total++;
        if (q !== 8'h00) $display("FAIL reset_q: got %h want 00", q);
        else n_pass++;
    endtask

    // One frame; a we pulse mid-frame and changes to d must have no effect.
    task automatic test_tx(input logic [7:0] b);
        logic [9:0]   fb;
        logic [100:0] obs_line, exp_line, obs_busy, exp_busy;
        int           tail_bad;
        fb = frame_bits(b, 1'b1);
        for (int k = 0; k <= 100; k++) begin
            exp_line[k] = (k < 100) ? fb[k / BITC] : 1'b1;
            exp_busy[k] = (k < 100);
        end
        @(negedge clock);
        d  = b;
        we = 1'b1;
        @(posedge clock);
        for (int k = 0; k <= 100; k++) begin
            @(negedge clock);
            obs_line[k] = serial_out;
            obs_busy[k] = busy;
            if (k == 0) begin
                we = 1'b0;
                d  = ~b;
            end
            if (k == 49) we = 1'b1;
            if (k == 50) begin
                we = 1'b0;
                d  = 8'($urandom);
            end
        end
        tail_bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (serial_out !== 1'b1 || busy !== 1'b0) tail_bad++;
        end
        n_total++;
        if (obs_line !== exp_line)
            $display("FAIL tx_line_%h: got %h want %h", b, obs_line, exp_line);
        else n_pass++;
        n_total++;
        if (obs_busy !== exp_busy)
            $display("FAIL tx_busy_%h: got %h want %h", b, obs_busy, exp_busy);
        else n_pass++;
        n_total++;
        if (tail_bad !== 0)
            $display("FAIL tx_no_second_frame_%h: got %0d active cycles want 0", b, tail_bad);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int resumed;
        @(negedge clock);
        d  = 8'h00;
        we = 1'b1;
        @(posedge clock);
        @(negedge clock);
        we = 1'b0;
        repeat (25) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (serial_out !== 1'b1) $display("FAIL midreset_serial_out: got %b want 1", serial_out);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy);
        else n_pass++;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        resumed = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (serial_out !== 1'b1 || busy !== 1'b0) resumed++;
        end
        n_total++;
        if (resumed !== 0) $display("FAIL midreset_abort: got %0d active cycles want 0", resumed);
        else n_pass++;
    endtask

    task automatic test_rx(input logic [7:0] b);
        int         t0, lat, held_bad;
        logic [7:0] first;
        got_q.delete();
        got_t.delete();
        @(negedge clock);
        t0 = cyc;
        send_frame(b, 1'b1);
        repeat (20) @(negedge clock);
        first = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        lat   = (got_t.size() > 0) ? got_t[0] - t0 : -1;
        n_total++;
        if (got_q.size() !== 1) $display("FAIL rx_count_%h: got %0d pulses want 1", b, got_q.size());
        else n_pass++;
        n_total++;
        if (first !== b) $display("FAIL rx_data: got %h want %h", first, b);
        else n_pass++;
        n_total++;
        if (lat < 90 || lat > 105)
            $display("FAIL rx_latency_%h: got %0d cycles want 90..105", b, lat);
        else n_pass++;
        held_bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (q !== b) held_bad++;
        end
        n_total++;
        if (held_bad !== 0) $display("FAIL rx_hold_%h: got %0d cycles changed want 0", b, held_bad);
        else n_pass++;
    endtask

    task automatic test_rx_back_to_back();
        logic [7:0]  b0, b1;
        logic [15:0] obs;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        got_q.delete();
        got_t.delete();
        @(negedge clock);
        send_frame(b0, 1'b1);
        send_frame(b1, 1'b1);
        repeat (20) @(negedge clock);
        obs = {(got_q.size() > 0) ? got_q[0] : 8'hxx, (got_q.size() > 1) ? got_q[1] : 8'hxx};
        n_total++;
        if (got_q.size() !== 2) $display("FAIL rx_b2b_count: got %0d want 2", got_q.size());
        else n_pass++;
        n_total++;
        if (obs !== {b0, b1}) $display("FAIL rx_b2b_data: got %h want %h", obs, {b0, b1});
        else n_pass++;
    endtask

    task automatic test_glitch();
        logic [7:0] qb;
        qb = q;
        got_q.delete();
        got_t.delete();
        @(negedge clock);
        tb_rx = 1'b0;
        repeat (3) @(negedge clock);
        tb_rx = 1'b1;
        repeat (120) @(negedge clock);
        n_total++;
        if (got_q.size() !== 0) $display("FAIL glitch_valid: got %0d pulses want 0", got_q.size());
        else n_pass++;
        n_total++;
        if (q !== qb) $display("FAIL glitch_q: got %h want %h", q, qb);
        else n_pass++;
    endtask

    task automatic test_framing();
        logic [7:0] qb;
        qb = q;
        got_q.delete();
        got_t.delete();
        n_ferr = 0;
        @(negedge clock);
        send_frame(8'($urandom), 1'b0);
        repeat (20) @(negedge clock);
        tb_rx = 1'b1;
        repeat (30) @(negedge clock);
        n_total++;
        if (got_q.size() !== 0) $display("FAIL framing_valid: got %0d pulses want 0", got_q.size());
        else n_pass++;
        n_total++;
        if (q !== qb) $display("FAIL framing_q: got %h want %h", q, qb);
        else n_pass++;
`ifdef RS232_FRAMING_ERR_EN
        n_total++;
        if (n_ferr !== 1) $display("FAIL framing_error_pulse: got %0d want 1", n_ferr);
        else n_pass++;
`endif
    endtask

    task automatic test_loopback();
        int          gaps;
        logic        busy_end;
        logic [23:0] obs;
        loop_en = 1'b1;
        got_q.delete();
        got_t.delete();
        gaps     = 0;
        busy_end = 1'bx;
        @(negedge clock);
        d  = 8'h00;
        we = 1'b1;
        @(posedge clock);
        for (int k = 0; k <= 330; k++) begin
            @(negedge clock);
            if (k < 300 && busy !== 1'b1) gaps++;
            if (k == 300) busy_end = busy;
            if (k == 0)   d  = 8'hFF;
            if (k == 100) d  = 8'h5A;
            if (k == 200) we = 1'b0;
        end
        obs = {(got_q.size() > 0) ? got_q[0] : 8'hxx,
               (got_q.size() > 1) ? got_q[1] : 8'hxx,
               (got_q.size() > 2) ? got_q[2] : 8'hxx};
        n_total++;
        if (gaps !== 0) $display("FAIL loop_busy_gap: got %0d idle cycles want 0", gaps);
        else n_pass++;
        n_total++;
        if (busy_end !== 1'b0) $display("FAIL loop_busy_end: got %b want 0", busy_end);
        else n_pass++;
        n_total++;
        if (got_q.size() !== 3) $display("FAIL loop_count: got %0d want 3", got_q.size());
        else n_pass++;
        n_total++;
        if (obs !== 24'h00FF5A) $display("FAIL loop_data: got %h want 00ff5a", obs);
        else n_pass++;
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx(8'h55);
        test_tx(8'($urandom));
        test_tx(8'($urandom));
        test_reset_midframe();
        test_rx(8'hA3);
        test_rx(8'($urandom));
        test_rx(8'($urandom));
        test_rx_back_to_back();
        test_glitch();
        test_framing();
        test_rx(8'($urandom));
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
